// File: rtl/gpio_sched_pkg.sv
// Shared types and default sizes for the GPIO pulse scheduler.
package gpio_sched_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned HALF_W_DEF = 27;
  localparam int unsigned PCNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // Index width for n requesters; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module gpio_rr_arbiter
  import gpio_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in priority order starting at the pointer; keep the first hit.
  always_comb begin
    o_gnt_c   = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(i_ptr) + i) % N_REQ);
      if (!o_valid_c && i_req[cand]) begin
        o_valid_c     = 1'b1;
        o_gnt_c[cand] = 1'b1;
        o_idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/gpio_pulse_scheduler.sv
// Shares one GPIO pin among requesters: round-robin pick, then a burst of square pulses, then ack.
module gpio_pulse_scheduler
  import gpio_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned HALF_W = HALF_W_DEF,
  parameter int unsigned PCNT_W = PCNT_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*HALF_W-1:0]  i_half_period,
  input  logic [N_REQ*PCNT_W-1:0]  i_pulse_cnt,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_busy,
  output logic                     o_gpio
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [PCNT_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] phase_q, phase_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              gpio_q, gpio_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [HALF_W-1:0] sel_half;
  logic [PCNT_W-1:0] sel_cnt;
  logic [IDX_W-1:0]  ptr_next;
  logic              phase_last;
  logic [PCNT_W-1:0] pcnt_inc;

  gpio_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req     (i_req),
    .i_ptr     (ptr_q),
    .o_gnt_c   (arb_gnt),
    .o_idx_c   (arb_idx),
    .o_valid_c (arb_valid)
  );

  // Winner's configuration slice, pointer successor and counter terminal conditions.
  always_comb begin
    sel_half   = i_half_period[32'(arb_idx) * HALF_W +: HALF_W];
    sel_cnt    = i_pulse_cnt[32'(arb_idx) * PCNT_W +: PCNT_W];
    ptr_next   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    phase_last = (phase_q == half_q - HALF_W'(1));
    pcnt_inc   = pcnt_q + PCNT_W'(1);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arb_valid) state_d = (sel_cnt == '0) ? DONE : HIGH;
      HIGH: if (phase_last) state_d = LOW;
      LOW:  if (phase_last) state_d = (pcnt_inc == cnt_q) ? DONE : HIGH;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output flop next values; config only latched on leaving IDLE.
  always_comb begin
    ptr_d   = ptr_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    gpio_d  = gpio_q;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          ptr_d   = ptr_next;
          half_d  = (sel_half == '0) ? HALF_W'(1) : sel_half;
          cnt_d   = sel_cnt;
          phase_d = '0;
          pcnt_d  = '0;
          if (sel_cnt == '0) begin
            grant_d = '0;
            ack_d   = arb_gnt;
            gpio_d  = 1'b0;
          end else begin
            grant_d = arb_gnt;
            gpio_d  = 1'b1;
          end
        end
      end
      HIGH: begin
        if (phase_last) begin
          phase_d = '0;
          gpio_d  = 1'b0;
        end else begin
          phase_d = phase_q + HALF_W'(1);
        end
      end
      LOW: begin
        if (phase_last) begin
          phase_d = '0;
          pcnt_d  = pcnt_inc;
          if (pcnt_inc == cnt_q) begin
            grant_d = '0;
            ack_d   = grant_q;
            gpio_d  = 1'b0;
          end else begin
            gpio_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + HALF_W'(1);
        end
      end
      DONE: begin
        grant_d = '0;
        gpio_d  = 1'b0;
      end
      default: begin
        grant_d = '0;
        gpio_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output flops; reset aborts any burst without an ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      half_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      pcnt_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gpio_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      gpio_q  <= gpio_d;
    end
  end

  assign o_grant = grant_q;
  assign o_ack   = ack_q;
  assign o_busy  = busy_q;
  assign o_gpio  = gpio_q;

endmodule
